// File: rtl/aes_stream_pkg.sv
// Shared word/block types for the AES 32-bit stream stacking and unstacking paths.
package aes_stream_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned WORDS   = 4;
    localparam int unsigned BLOCK_W = WORD_W * WORDS;
    localparam int unsigned IDX_W   = $clog2(WORDS);

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [IDX_W-1:0]   word_idx_t;

    localparam word_idx_t LAST_IDX = word_idx_t'(WORDS - 1);

    // Occupancy of the two-entry block buffer
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Word idx of a block, word 0 being the most-significant slice
    function automatic word_t get_word(input block_t blk, input word_idx_t idx);
        word_t w;
        w = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (word_idx_t'(i) == idx) begin
                w = blk[BLOCK_W-1-i*WORD_W -: WORD_W];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/block_unstacker_if.sv
// Block-in / word-out stream bundle; slave is the unstacker side, master the environment side.
interface block_unstacker_if;
    import aes_stream_pkg::*;

    logic   valid_i;
    logic   ready_o;
    block_t block_i;
    logic   valid_o;
    logic   ready_i;
    word_t  word_o;
    logic   last_o;

    modport slave (
        input  valid_i,
        input  block_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output word_o,
        output last_o
    );

    modport master (
        output valid_i,
        output block_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  word_o,
        input  last_o
    );
endinterface

// File: rtl/block_unstacker_fifo2.sv
// Two-entry block buffer: write/read pointers, occupancy FSM, retired entries zeroed.
module block_unstacker_fifo2
    import aes_stream_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   clr_i,
    input  logic   push,
    input  block_t wdata,
    input  logic   pop,
    output block_t head,
    output logic   full,
    output logic   empty
);

    occ_e   state;
    occ_e   state_nx;
    logic   wr_ptr;
    logic   rd_ptr;
    block_t entry [2];

    // Occupancy state register
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Occupancy next state; push and pop in ONE leaves occupancy unchanged
    always_comb begin
        state_nx = state;
        unique case (state)
            OCC_EMPTY: if (push) state_nx = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop) begin
                    state_nx = OCC_FULL;
                end else if (pop && !push) begin
                    state_nx = OCC_EMPTY;
                end
            end
            OCC_FULL:  if (pop) state_nx = OCC_ONE;
            default:   state_nx = OCC_EMPTY;
        endcase
    end

    // Entry storage and pointers; with one entry held, push and pop never share an index
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            entry[0] <= '0;
            entry[1] <= '0;
        end else begin
            if (pop) begin
                entry[rd_ptr] <= '0;
                rd_ptr        <= ~rd_ptr;
            end
            if (push) begin
                entry[wr_ptr] <= wdata;
                wr_ptr        <= ~wr_ptr;
            end
        end
    end

    assign head  = entry[rd_ptr];
    assign full  = (state == OCC_FULL);
    assign empty = (state == OCC_EMPTY);

endmodule

// File: rtl/block_unstacker.sv
// Splits 128-bit AES result blocks into four 32-bit words, most-significant word first.
module block_unstacker
    import aes_stream_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic enable_i,
    block_unstacker_if.slave bus
);

    word_idx_t word_idx;
    block_t    head;
    logic      full;
    logic      empty;
    logic      accept;
    logic      xfer;
    logic      retire;

    // Handshakes are gated by enable so a low enable freezes all state
    assign bus.ready_o = enable_i & ~full;
    assign bus.valid_o = enable_i & ~empty;
    assign accept      = bus.valid_i & bus.ready_o;
    assign xfer        = bus.valid_o & bus.ready_i;
    assign retire      = xfer & (word_idx == LAST_IDX);

    block_unstacker_fifo2 u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clr_i),
        .push  (accept),
        .wdata (bus.block_i),
        .pop   (retire),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Word position within the head block; wraps when the block retires
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            word_idx <= '0;
        end else if (xfer) begin
            word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + word_idx_t'(1);
        end
    end

    assign bus.word_o = bus.valid_o ? get_word(head, word_idx) : '0;
    assign bus.last_o = bus.valid_o & (word_idx == LAST_IDX);

endmodule
